// File: rtl/hash_set_pkg.sv
// Shared encodings and width helpers for the hash membership checker.
package hash_set_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_CHECK  = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width, never zero so single-entry configurations still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hash_block_compare.sv
// Compares one block of LANES stored hashes against a key and returns the
// lowest valid matching lane.
module hash_block_compare
    import hash_set_pkg::*;
#(
    parameter int HASH_WIDTH = 128,
    parameter int LANES      = 8,
    localparam int LW        = idx_width(LANES)
) (
    input  logic [HASH_WIDTH-1:0]            key_i,
    input  logic [LANES-1:0][HASH_WIDTH-1:0] lane_hash_i,
    input  logic [LANES-1:0]                 lane_valid_i,
    output logic                             hit_o,
    output logic [LW-1:0]                    hit_lane_o
);

    logic [LANES-1:0] lane_hit;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi] = lane_valid_i[gi] && (lane_hash_i[gi] == key_i);
        end
    endgenerate

    // Walk from the top lane down so the lowest hit wins.
    always_comb begin
        hit_o      = |lane_hit;
        hit_lane_o = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) begin
                hit_lane_o = LW'(l);
            end
        end
    end

endmodule

// File: rtl/hash_set_checker.sv
// Stores up to DEPTH hashes and answers insert/check/clear commands over a
// valid/ready port; checks scan LANES slots per cycle and stop at the first hit.
module hash_set_checker
    import hash_set_pkg::*;
#(
    parameter int HASH_WIDTH = 128,
    parameter int DEPTH      = 128,
    parameter int LANES      = 8,
    localparam int IW        = idx_width(DEPTH),
    localparam int CW        = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [HASH_WIDTH-1:0] cmd_hash,
    output logic                  resultrdy,
    output logic                  matchfound,
    output logic [IW-1:0]         match_index,
    output logic                  error,
    output logic [CW-1:0]         count,
    output logic                  full
);

    localparam int NBLK = DEPTH / LANES;
    localparam int BW   = idx_width(NBLK);
    localparam int LW   = idx_width(LANES);

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         block_q, block_d;
    logic [HASH_WIDTH-1:0] key_q, key_d;
    logic                  match_q, match_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  err_q, err_d;

    logic [HASH_WIDTH-1:0] mem_q [DEPTH];

    logic                             accept;
    logic                             full_w;
    logic                             mem_we;
    logic [CW-1:0]                    base_slot;
    logic [CW-1:0]                    lane_slot [LANES];
    logic [LANES-1:0][HASH_WIDTH-1:0] lane_hash;
    logic [LANES-1:0]                 lane_valid;
    logic                             blk_hit;
    logic [LW-1:0]                    blk_lane;
    logic                             last_block;

    assign accept     = cmd_valid && (state_q == IDLE);
    assign full_w     = (count_q == CW'(DEPTH));
    assign base_slot  = CW'(block_q) * CW'(LANES);
    assign last_block = (base_slot + CW'(LANES)) >= count_q;

    // Asynchronous read of the current block; slots at or above count are
    // masked so stale contents left behind by clear can never match.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
            assign lane_slot[gi]  = base_slot + CW'(gi);
            assign lane_hash[gi]  = mem_q[lane_slot[gi][IW-1:0]];
            assign lane_valid[gi] = lane_slot[gi] < count_q;
        end
    endgenerate

    hash_block_compare #(
        .HASH_WIDTH (HASH_WIDTH),
        .LANES      (LANES)
    ) u_cmp (
        .key_i        (key_q),
        .lane_hash_i  (lane_hash),
        .lane_valid_i (lane_valid),
        .hit_o        (blk_hit),
        .hit_lane_o   (blk_lane)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        block_d = block_q;
        key_d   = key_q;
        match_d = match_q;
        idx_d   = idx_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DONE;
                    case (cmd_op)
                        OP_INSERT: begin
                            if (!full_w) begin
                                mem_we  = 1'b1;
                                count_d = count_q + 1'b1;
                                err_d   = 1'b0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            count_d = '0;
                            err_d   = 1'b0;
                        end
                        OP_CHECK: begin
                            key_d   = cmd_hash;
                            block_d = '0;
                            err_d   = 1'b0;
                            if (count_q == '0) begin
                                match_d = 1'b0;
                            end else begin
                                state_d = SCAN;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            SCAN: begin
                if (blk_hit) begin
                    match_d = 1'b1;
                    idx_d   = base_slot[IW-1:0] + IW'(blk_lane);
                    state_d = DONE;
                end else if (last_block) begin
                    match_d = 1'b0;
                    state_d = DONE;
                end else begin
                    block_d = block_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            block_q <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Datapath only: the latched key and storage need no reset.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        if (mem_we && !reset) begin
            mem_q[count_q[IW-1:0]] <= cmd_hash;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign resultrdy   = (state_q == DONE);
    assign matchfound  = match_q;
    assign match_index = idx_q;
    assign error       = err_q;
    assign count       = count_q;
    assign full        = full_w;

endmodule

// File: tb/tb_hash_set_checker.sv
// Directed bench for hash_set_checker: a queue-based set model predicts
// latency and results, and a per-cycle compare process checks the DUT.
module tb_hash_set_checker;
    import hash_set_pkg::*;

    localparam int HW    = 128;
    localparam int DEPTH = 128;
    localparam int LANES = 8;
    localparam int IW    = 7;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [HW-1:0] cmd_hash;
    logic          resultrdy;
    logic          matchfound;
    logic [IW-1:0] match_index;
    logic          error;
    logic [CW-1:0] count;
    logic          full;

    always #5 clk = ~clk;

    hash_set_checker #(
        .HASH_WIDTH (HW),
        .DEPTH      (DEPTH),
        .LANES      (LANES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_hash    (cmd_hash),
        .resultrdy   (resultrdy),
        .matchfound  (matchfound),
        .match_index (match_index),
        .error       (error),
        .count       (count),
        .full        (full)
    );

    logic [HW-1:0] model_q [$];
    bit  pending;
    int  exp_lat;
    bit  exp_match;
    int  exp_idx;
    bit  exp_err;
    int  cyc;
    int  acc_cyc;
    int  last_exp_lat;
    bit  last_match;
    int  last_idx;
    bit  last_err;
    int  n_checks;
    int  n_pass;
    int  w;
    int  w2;

    initial begin
        cyc = 0; pending = 0; exp_match = 0; exp_idx = 0; exp_err = 0;
        n_checks = 0; n_pass = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [HW-1:0] hv(input int i);
        return {32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 32'(i)};
    endfunction

    // Set semantics: result depends only on queue contents, not on how the DUT scans.
    task automatic model_accept(input logic [1:0] op, input logic [HW-1:0] h);
        int found;
        acc_cyc = cyc;
        pending = 1;
        exp_lat = 1;
        case (op)
            2'b00: begin
                if (model_q.size() < DEPTH) begin
                    model_q.push_back(h);
                    exp_err = 0;
                end else exp_err = 1;
            end
            2'b10: begin model_q.delete(); exp_err = 0; end
            2'b01: begin
                exp_err = 0;
                found = -1;
                foreach (model_q[i]) if (found < 0 && model_q[i] == h) found = i;
                if (model_q.size() == 0) exp_match = 0;
                else if (found >= 0) begin
                    exp_match = 1; exp_idx = found; exp_lat = found / LANES + 2;
                end else begin
                    exp_match = 0; exp_lat = (model_q.size() + LANES - 1) / LANES + 1;
                end
            end
            default: exp_err = 1;
        endcase
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cmd_ready", cmd_ready, !pending);
            chk("count", count, model_q.size());
            chk("full", full, model_q.size() == DEPTH);
            if (pending && (cyc - acc_cyc + 1 == exp_lat)) begin
                chk("resultrdy", resultrdy, 1);
                chk("matchfound", matchfound, exp_match);
                chk("match_index", match_index, exp_idx);
                chk("error", error, exp_err);
                last_exp_lat = exp_lat;
                last_match   = matchfound;
                last_idx     = match_index;
                last_err     = error;
                pending      = 0;
            end else begin
                chk("resultrdy_low", resultrdy, 0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [HW-1:0] h, output int waited);
        bit r;
        int n;
        n = 0;
        cmd_valid = 1; cmd_op = op; cmd_hash = h;
        do begin
            @(negedge clk); r = cmd_ready;
            @(posedge clk); n++;
        end while (!r && n < 300);
        #1;
        cmd_valid = 0;
        waited = n;
        if (!r) chk("accept_timeout", 0, 1);
        else begin
            chk("no_overlap", pending, 0);
            model_accept(op, h);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (pending && n < 300) begin @(posedge clk); n++; end
        if (pending) begin chk("done_timeout", 0, 1); pending = 0; end
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic [HW-1:0] h);
        int wt;
        issue(op, h, wt);
        wait_done();
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_q.delete();
        pending = 0; exp_match = 0; exp_idx = 0; exp_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [HW-1:0] h1, aa, x, y;
        h1 = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
        aa = {16{8'hAA}};
        x  = hv(1000);
        y  = hv(3000);
        reset = 1; cmd_valid = 0; cmd_op = 2'b00; cmd_hash = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        chk("rst_ready", cmd_ready, 1);
        chk("rst_resultrdy", resultrdy, 0);
        chk("rst_match", matchfound, 0);
        chk("rst_index", match_index, 0);
        chk("rst_error", error, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);

        run(OP_INSERT, h1);
        run(OP_CHECK, h1);
        chk("t1_lat", last_exp_lat, 2);
        chk("t1_match", last_match, 1);
        chk("t1_idx", last_idx, 0);
        chk("t1_count", count, 1);

        run(OP_CLEAR, '0);
        for (int i = 0; i < DEPTH; i++) run(OP_INSERT, hv(i));
        run(OP_CHECK, hv(127));
        chk("last_blk_lat", last_exp_lat, 17);
        chk("last_blk_idx", last_idx, 127);
        run(OP_CHECK, hv(500));
        chk("miss_lat", last_exp_lat, 17);
        chk("miss_match", last_match, 0);
        chk("full_set", full, 1);

        run(OP_INSERT, aa);
        chk("ovf_err", last_err, 1);
        chk("ovf_lat", last_exp_lat, 1);
        chk("ovf_count", count, 128);
        run(OP_CHECK, aa);
        chk("ovf_check", last_match, 0);

        run(OP_CLEAR, '0);
        chk("clr_lat", last_exp_lat, 1);
        chk("clr_count", count, 0);
        chk("clr_full", full, 0);
        run(OP_CHECK, hv(5));
        chk("empty_lat", last_exp_lat, 1);
        chk("empty_match", last_match, 0);

        for (int i = 0; i < 11; i++) run(OP_INSERT, (i == 3 || i == 10) ? x : hv(2000 + i));
        chk("dup_count", count, 11);
        run(OP_CHECK, x);
        chk("dup_idx", last_idx, 3);
        chk("dup_lat", last_exp_lat, 2);
        run(OP_CLEAR, '0);
        run(OP_INSERT, y);
        run(OP_INSERT, y);
        run(OP_CHECK, x);
        chk("mask_miss", last_match, 0);

        run(OP_RSVD, x);
        chk("rsvd_err", last_err, 1);
        chk("rsvd_lat", last_exp_lat, 1);

        run(OP_CLEAR, '0);
        for (int i = 0; i < 20; i++) run(OP_INSERT, hv(i));
        issue(OP_CHECK, hv(19), w);
        issue(OP_INSERT, hv(77), w2);
        chk("bp_wait", w2, 5);
        wait_done();
        chk("bp_count", count, 21);

        issue(OP_CHECK, hv(500), w);
        @(posedge clk); #1;
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_count", count, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_match", matchfound, 0);

        run(OP_INSERT, hv(1));
        run(OP_CHECK, hv(1));
        chk("post_rst_match", last_match, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
